// File: rtl/div_ctrl_pkg.sv
// Shared state encodings and control constants for the EX-stage divide controller.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_ZERO = 2'b01,
    DIV_ON   = 2'b10,
    DIV_END  = 2'b11
  } div_state_t;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_ctrl_if.sv
// EX-stage <-> divider handshake: the pipeline (master) requests, the divider (slave) stalls and returns {HI, LO}.
interface div_ctrl_if #(parameter int WIDTH = 32);

  logic               start;
  logic               signed_div;
  logic [WIDTH-1:0]   opdata1;
  logic [WIDTH-1:0]   opdata2;
  logic               annul;
  logic               stall_div;
  logic               ready;
  logic [2*WIDTH-1:0] result;

  modport master (
    output start, signed_div, opdata1, opdata2, annul,
    input  stall_div, ready, result
  );

  modport slave (
    input  start, signed_div, opdata1, opdata2, annul,
    output stall_div, ready, result
  );

endinterface

// File: rtl/div_step.sv
// One radix-2 restoring iteration on a {remainder, quotient} register; purely combinational.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] rem_quo,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] rem_quo_nxt
);

  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  // The trial keeps the bit shifted out of the remainder, hence WIDTH+1 bits.
  assign trial = rem_quo[2*WIDTH-1:WIDTH-1];
  assign diff  = trial - {1'b0, divisor};

  always_comb begin
    rem_quo_nxt = {rem_quo[2*WIDTH-2:0], 1'b0};
    if (!diff[WIDTH]) begin
      rem_quo_nxt = {diff[WIDTH-1:0], rem_quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// Multicycle DIV/DIVU controller: WIDTH+1 cycles start-to-ready (2 for a zero divisor), stalls EX until done.
// Holds the result in END while start stays high; annul aborts to IDLE with the previous result kept.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  div_ctrl_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);

  div_state_t         state;
  div_state_t         state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] work;
  logic [2*WIDTH-1:0] work_nxt;
  logic [WIDTH-1:0]   divisor;
  logic               sign_a;
  logic               sign_b;
  logic               sgn;
  logic               ready_q;
  logic [2*WIDTH-1:0] result_q;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic               last_iter;

  assign last_iter = (cnt == CW'(WIDTH - 1));

  assign abs_a = (bus.signed_div && bus.opdata1[WIDTH-1]) ? -bus.opdata1 : bus.opdata1;
  assign abs_b = (bus.signed_div && bus.opdata2[WIDTH-1]) ? -bus.opdata2 : bus.opdata2;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_quo     (work),
    .divisor     (divisor),
    .rem_quo_nxt (work_nxt)
  );

  // Sign fix-up uses the final iteration's output so it lands in result on the same edge.
  assign quo_fix = (sgn && (sign_a ^ sign_b)) ? -work_nxt[WIDTH-1:0] : work_nxt[WIDTH-1:0];
  assign rem_fix = (sgn && sign_a) ? -work_nxt[2*WIDTH-1:WIDTH] : work_nxt[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DIV_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (bus.annul) begin
      state_nxt = DIV_IDLE;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (bus.start == DIV_START) begin
            state_nxt = (bus.opdata2 == '0) ? DIV_ZERO : DIV_ON;
          end
        end
        DIV_ZERO: state_nxt = DIV_END;
        DIV_ON:   if (last_iter) state_nxt = DIV_END;
        DIV_END:  if (bus.start == DIV_STOP) state_nxt = DIV_IDLE;
        default:  state_nxt = DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      work     <= '0;
      divisor  <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      sgn      <= 1'b0;
      ready_q  <= DIV_RESULT_NOT_READY;
      result_q <= '0;
    end else begin
      ready_q <= (state_nxt == DIV_END) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
      case (state)
        DIV_IDLE: begin
          if (state_nxt == DIV_ON) begin
            work    <= {{WIDTH{1'b0}}, abs_a};
            divisor <= abs_b;
            sign_a  <= bus.opdata1[WIDTH-1];
            sign_b  <= bus.opdata2[WIDTH-1];
            sgn     <= bus.signed_div;
            cnt     <= '0;
          end
        end
        DIV_ZERO: begin
          if (state_nxt == DIV_END) result_q <= '0;
        end
        DIV_ON: begin
          work <= work_nxt;
          cnt  <= cnt + 1'b1;
          if (state_nxt == DIV_END) result_q <= {rem_fix, quo_fix};
        end
        default: ;
      endcase
    end
  end

  assign bus.stall_div = bus.start & ~ready_q & ~bus.annul;
  assign bus.ready     = ready_q;
  assign bus.result    = result_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Randomized and directed bench for div_ctrl against an arithmetic reference of DIV/DIVU.
module tb_div_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [63:0] last_res;

  div_ctrl_if #(.WIDTH(32)) bus ();

  div_ctrl #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer division, truncating toward zero, remainder takes the dividend's sign.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Entered just after a rising edge with the DUT idle; leaves the same way.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, input logic [63:0] exp, input int lat, input int hold);
    bus.start      = 1'b1;
    bus.signed_div = sgn;
    bus.opdata1    = a;
    bus.opdata2    = b;
    for (int cyc = 0; cyc <= lat + hold; cyc++) begin
      @(negedge clk);
      checks++;
      if (cyc < lat) begin
        if (bus.ready !== 1'b0 || bus.stall_div !== 1'b1) begin
          errors++;
          $display("FAIL %s cyc %0d: ready=%b stall=%b, want ready=0 stall=1",
                   name, cyc, bus.ready, bus.stall_div);
        end
      end else begin
        if (bus.ready !== 1'b1 || bus.stall_div !== 1'b0 || bus.result !== exp) begin
          errors++;
          $display("FAIL %s cyc %0d: ready=%b stall=%b result=%h, want ready=1 stall=0 result=%h",
                   name, cyc, bus.ready, bus.stall_div, bus.result, exp);
        end
      end
      @(posedge clk);
      #1;
      bus.opdata1    = $urandom;
      bus.opdata2    = $urandom;
      bus.signed_div = 1'($urandom_range(0, 1));
    end
    bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.ready !== 1'b1 || bus.stall_div !== 1'b0) begin
      errors++;
      $display("FAIL %s release: ready=%b stall=%b, want ready=1 stall=0", name, bus.ready, bus.stall_div);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (bus.ready !== 1'b0 || bus.stall_div !== 1'b0 || bus.result !== exp) begin
      errors++;
      $display("FAIL %s idle: ready=%b stall=%b result=%h, want ready=0 stall=0 result=%h",
               name, bus.ready, bus.stall_div, bus.result, exp);
    end
    last_res = exp;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.signed_div = 1'b0;
    bus.opdata1    = '0;
    bus.opdata2    = '0;
    bus.annul      = 1'b0;
    last_res       = '0;
    #3;
    checks++;
    if (bus.ready !== 1'b0 || bus.result !== 64'd0 || bus.stall_div !== 1'b0) begin
      errors++;
      $display("FAIL reset: ready=%b stall=%b result=%h, want 0 0 0", bus.ready, bus.stall_div, bus.result);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    run_op("divu_100_7", 32'd100, 32'd7, 1'b0, {32'h2, 32'hE}, 33, 0);
    run_op("div_m100_7", 32'hFFFFFF9C, 32'd7, 1'b1, {32'hFFFFFFFE, 32'hFFFFFFF2}, 33, 0);
    run_op("div_100_m7", 32'd100, 32'hFFFFFFF9, 1'b1, {32'h2, 32'hFFFFFFF2}, 33, 0);
    run_op("div_5_0", 32'd5, 32'd0, 1'b1, 64'd0, 2, 0);
    run_op("divu_max_1", 32'hFFFFFFFF, 32'd1, 1'b0, {32'h0, 32'hFFFFFFFF}, 33, 0);
    run_op("div_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h0, 32'h80000000}, 33, 0);
  endtask

  task automatic test_hold();
    run_op("hold_divu", 32'd1000, 32'd33, 1'b0, {32'd10, 32'd30}, 33, 5);
    run_op("hold_zero", 32'd77, 32'd0, 1'b0, 64'd0, 2, 5);
  endtask

  task automatic test_annul();
    bus.start      = 1'b1;
    bus.signed_div = 1'b0;
    bus.opdata1    = 32'd100;
    bus.opdata2    = 32'd7;
    repeat (10) @(posedge clk);
    #1;
    bus.annul = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.stall_div !== 1'b0 || bus.ready !== 1'b0) begin
      errors++;
      $display("FAIL annul_cyc10: stall=%b ready=%b, want 0 0", bus.stall_div, bus.ready);
    end
    @(posedge clk);
    #1;
    bus.annul = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.ready !== 1'b0 || bus.stall_div !== 1'b0 || bus.result !== last_res) begin
      errors++;
      $display("FAIL annul_cyc11: ready=%b stall=%b result=%h, want 0 0 %h",
               bus.ready, bus.stall_div, bus.result, last_res);
    end
    @(posedge clk);
    #1;
    run_op("divu_9_2_after_annul", 32'd9, 32'd2, 1'b0, {32'd1, 32'd4}, 33, 0);
  endtask

  task automatic test_reset_mid();
    bus.start      = 1'b1;
    bus.signed_div = 1'b0;
    bus.opdata1    = 32'd100;
    bus.opdata2    = 32'd7;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.ready !== 1'b0 || bus.result !== 64'd0) begin
      errors++;
      $display("FAIL reset_mid: ready=%b result=%h, want 0 0", bus.ready, bus.result);
    end
    last_res  = '0;
    #2;
    rst       = 1'b0;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (bus.ready !== 1'b0 || bus.stall_div !== 1'b0 || bus.result !== 64'd0) begin
      errors++;
      $display("FAIL reset_mid_idle: ready=%b stall=%b result=%h, want 0 0 0",
               bus.ready, bus.stall_div, bus.result);
    end
    @(posedge clk);
    #1;
    run_op("divu_9_2_after_rst", 32'd9, 32'd2, 1'b0, {32'd1, 32'd4}, 33, 0);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic        sgn;
    for (int i = 0; i < 25; i++) begin
      case ($urandom_range(0, 5))
        0:       a = 32'h80000000;
        1:       a = 32'hFFFFFFFF;
        2:       a = $urandom_range(0, 50);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0:       b = 32'd0;
        1:       b = 32'd1;
        2:       b = 32'hFFFFFFFF;
        3:       b = $urandom_range(1, 20);
        default: b = $urandom;
      endcase
      sgn = 1'($urandom_range(0, 1));
      run_op($sformatf("rand%0d", i), a, b, sgn, ref_div(a, b, sgn),
             (b == 32'd0) ? 2 : 33, $urandom_range(0, 2));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_hold();
    test_annul();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
